sdf_scene_combiner: RTL and testbench

// - Parametrised CSG combiner for the raymarcher distance stage: folds NUM_PRIM primitive SDF outputs into one scene distance.
// - Each primitive pipeline (box, sphere, menger, ...) has its own latency; this block aligns them, applies a per-channel op, and pipelines the fold.
// - Replaces fixed, hand-wired union/difference instances; the op set is runtime-programmable and applied atomically between samples.
// - Also emits the index of the primitive that produced the result, for shading.

---
 rtl/sdf_scene_combiner_pkg.sv | 23 ++
 rtl/sdf_scene_combiner_fold_stage.sv | 75 +++++++
 rtl/sdf_scene_combiner.sv | 169 ++++++++++++++++
 tb/tb_sdf_scene_combiner.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdf_scene_combiner_pkg.sv
// Shared FP27 field layout, literals and CSG op codes for the scene combiner.
package sdf_scene_combiner_pkg;

    localparam int FP_W      = 27;
    localparam int FP_SIGN   = 26;
    localparam int FP_EXP_HI = 25;
    localparam int FP_EXP_LO = 18;
    localparam int FP_MAN_HI = 17;
    localparam int FP_MAN_LO = 0;

    localparam logic [FP_W-1:0] FP_MAX_POS = 27'h3FBFFFF;
    localparam logic [FP_W-1:0] FP_ONE     = 27'h1FC0000;
    localparam logic [FP_W-1:0] FP_HALF    = 27'h1F80000;
    localparam logic [FP_W-1:0] FP_TWO     = 27'h2000000;

    typedef enum logic [1:0] {
        OP_UNION = 2'b00,
        OP_INTER = 2'b01,
        OP_SUB   = 2'b10,
        OP_OFF   = 2'b11
    } op_e;

endpackage

// File: rtl/sdf_scene_combiner_fold_stage.sv
// One registered CSG fold step: merges channel K into the running distance/id.
module sdf_fold_stage
    import sdf_scene_combiner_pkg::*;
#(
    parameter int NUM_PRIM = 4,
    parameter int DW       = 27,
    parameter int ID_W     = 3,
    parameter int K        = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [DW-1:0]          in_acc,
    input  logic [ID_W-1:0]        in_id,
    input  logic [NUM_PRIM*DW-1:0] in_dist,
    input  logic [2*NUM_PRIM-1:0]  in_ops,
    output logic                   out_valid,
    output logic [DW-1:0]          out_acc,
    output logic [ID_W-1:0]        out_id,
    output logic [NUM_PRIM*DW-1:0] out_dist,
    output logic [2*NUM_PRIM-1:0]  out_ops
);

    // Sign-magnitude mapped onto a two's-complement key; -0 and +0 both map to 0.
    function automatic logic signed [FP_W:0] fp_key(input logic [FP_W-1:0] v);
        logic signed [FP_W:0] mag;
        mag = {2'b00, v[FP_EXP_HI:0]};
        return v[FP_SIGN] ? -mag : mag;
    endfunction

    function automatic logic fp_gt(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
        return fp_key(a) > fp_key(b);
    endfunction

    logic [DW-1:0] dk;
    logic [DW-1:0] dk_neg;
    logic [DW-1:0] cand;
    logic          take;

    assign dk     = in_dist[DW*K +: DW];
    assign dk_neg = {~dk[DW-1], dk[DW-2:0]};

    always_comb begin
        take = 1'b0;
        cand = dk;
        case (op_e'(in_ops[2*K +: 2]))
            OP_UNION: take = fp_gt(in_acc, dk);
            OP_INTER: take = fp_gt(dk, in_acc);
            OP_SUB: begin
                take = fp_gt(dk_neg, in_acc);
                cand = dk_neg;
            end
            default:  take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_id    <= '0;
            out_dist  <= '0;
            out_ops   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_acc  <= take ? cand : in_acc;
                out_id   <= take ? ID_W'(K) : in_id;
                out_dist <= in_dist;
                out_ops  <= in_ops;
            end
        end
    end

endmodule

// File: rtl/sdf_scene_combiner.sv
// Aligns NUM_PRIM primitive SDF channels of differing latency and folds them with
// runtime-programmable CSG ops into one scene distance plus the winning channel index.
module sdf_scene_combiner
    import sdf_scene_combiner_pkg::*;
#(
    parameter int          NUM_PRIM = 4,
    parameter int          DW       = 27,
    parameter int          MAX_LAT  = 16,
    parameter logic [63:0] LAT_VEC  = {8{8'd0}},
    parameter int          ID_W     = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_valid,
    input  logic [NUM_PRIM*DW-1:0] i_dist,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_ch,
    input  logic [1:0]             cfg_op,
    input  logic                   cfg_commit,
    output logic                   o_valid,
    output logic [DW-1:0]          o_dist,
    output logic [ID_W-1:0]        o_id
);

    if (NUM_PRIM < 2 || NUM_PRIM > 8) begin : g_bad_num_prim
        $error("sdf_scene_combiner: NUM_PRIM=%0d outside 2..8", NUM_PRIM);
    end
    if (ID_W < $clog2(NUM_PRIM)) begin : g_bad_id_w
        $error("sdf_scene_combiner: ID_W=%0d too narrow for NUM_PRIM=%0d", ID_W, NUM_PRIM);
    end
    if (DW != FP_W) begin : g_bad_dw
        $error("sdf_scene_combiner: DW must be %0d", FP_W);
    end

    logic [2*NUM_PRIM-1:0] shadow_ops;
    logic [2*NUM_PRIM-1:0] active_ops;

    // Commit copies the pre-write shadow because both update on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_ops <= '0;
            active_ops <= '0;
        end else begin
            for (int i = 0; i < NUM_PRIM; i++) begin
                if (cfg_we && cfg_ch == 3'(i)) shadow_ops[2*i +: 2] <= cfg_op;
            end
            if (cfg_commit) active_ops <= shadow_ops;
        end
    end

    logic                   al_valid;
    logic [2*NUM_PRIM-1:0]  al_ops;
    logic [NUM_PRIM*DW-1:0] al_dist;

    if (MAX_LAT == 0) begin : g_snap_pass
        assign al_valid = i_valid;
        assign al_ops   = active_ops;
    end else begin : g_snap
        logic [MAX_LAT-1:0]    vld_sr;
        logic [2*NUM_PRIM-1:0] ops_sr [MAX_LAT];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_sr <= '0;
                for (int j = 0; j < MAX_LAT; j++) ops_sr[j] <= '0;
            end else begin
                vld_sr[0] <= i_valid;
                ops_sr[0] <= active_ops;
                for (int j = 1; j < MAX_LAT; j++) begin
                    vld_sr[j] <= vld_sr[j-1];
                    ops_sr[j] <= ops_sr[j-1];
                end
            end
        end

        assign al_valid = vld_sr[MAX_LAT-1];
        assign al_ops   = ops_sr[MAX_LAT-1];
    end

    for (genvar ch = 0; ch < NUM_PRIM; ch++) begin : g_chan
        localparam int LAT = int'(LAT_VEC[8*ch +: 8]);
        localparam int DLY = (MAX_LAT > LAT) ? MAX_LAT - LAT : 0;

        if (LAT > MAX_LAT) begin : g_bad_lat
            $error("sdf_scene_combiner: channel %0d latency %0d exceeds MAX_LAT %0d", ch, LAT, MAX_LAT);
        end

        if (DLY == 0) begin : g_pass
            assign al_dist[DW*ch +: DW] = i_dist[DW*ch +: DW];
        end else begin : g_dly
            logic [DW-1:0] sr [DLY];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int j = 0; j < DLY; j++) sr[j] <= '0;
                end else begin
                    sr[0] <= i_dist[DW*ch +: DW];
                    for (int j = 1; j < DLY; j++) sr[j] <= sr[j-1];
                end
            end

            assign al_dist[DW*ch +: DW] = sr[DLY-1];
        end
    end

    logic                   stg_valid [NUM_PRIM];
    logic [DW-1:0]          stg_acc   [NUM_PRIM];
    logic [ID_W-1:0]        stg_id    [NUM_PRIM];
    logic [NUM_PRIM*DW-1:0] stg_dist  [NUM_PRIM];
    logic [2*NUM_PRIM-1:0]  stg_ops   [NUM_PRIM];

    logic                   s0_valid;
    logic [DW-1:0]          s0_acc;
    logic [NUM_PRIM*DW-1:0] s0_dist;
    logic [2*NUM_PRIM-1:0]  s0_ops;

    // Fold stage 0: a disabled channel 0 seeds the accumulator with the largest positive value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_valid <= 1'b0;
            s0_acc   <= '0;
            s0_dist  <= '0;
            s0_ops   <= '0;
        end else begin
            s0_valid <= al_valid;
            if (al_valid) begin
                s0_acc  <= (op_e'(al_ops[1:0]) == OP_OFF) ? DW'(FP_MAX_POS) : al_dist[DW-1:0];
                s0_dist <= al_dist;
                s0_ops  <= al_ops;
            end
        end
    end

    assign stg_valid[0] = s0_valid;
    assign stg_acc[0]   = s0_acc;
    assign stg_id[0]    = '0;
    assign stg_dist[0]  = s0_dist;
    assign stg_ops[0]   = s0_ops;

    for (genvar k = 1; k < NUM_PRIM; k++) begin : g_fold
        sdf_fold_stage #(
            .NUM_PRIM(NUM_PRIM),
            .DW      (DW),
            .ID_W    (ID_W),
            .K       (k)
        ) u_stage (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_valid (stg_valid[k-1]),
            .in_acc   (stg_acc[k-1]),
            .in_id    (stg_id[k-1]),
            .in_dist  (stg_dist[k-1]),
            .in_ops   (stg_ops[k-1]),
            .out_valid(stg_valid[k]),
            .out_acc  (stg_acc[k]),
            .out_id   (stg_id[k]),
            .out_dist (stg_dist[k]),
            .out_ops  (stg_ops[k])
        );
    end

    assign o_valid = stg_valid[NUM_PRIM-1];
    assign o_dist  = stg_acc[NUM_PRIM-1];
    assign o_id    = stg_id[NUM_PRIM-1];

    logic unused_tail;
    assign unused_tail = ^{stg_dist[NUM_PRIM-1], stg_ops[NUM_PRIM-1]};

endmodule

// File: tb/tb_sdf_scene_combiner.sv
// Randomized bench for sdf_scene_combiner against a per-sample CSG reference model.
module tb_sdf_scene_combiner;

    localparam int NP      = 4;
    localparam int DW      = 27;
    localparam int MAXL    = 16;
    localparam int LATENCY = MAXL + NP;
    localparam int NC      = 2048;
    localparam logic [63:0] LATS = {32'd0, 8'd11, 8'd9, 8'd9, 8'd11};

    localparam logic [26:0] F_MAX   = 27'h3FBFFFF;
    localparam logic [26:0] F_ONE   = 27'h1FC0000;
    localparam logic [26:0] F_HALF  = 27'h1F80000;
    localparam logic [26:0] F_TWO   = 27'h2000000;
    localparam logic [26:0] F_NZERO = 27'h4000000;
    localparam logic [26:0] F_NONE  = 27'h5FC0000;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 i_valid = 1'b0;
    logic [NP*DW-1:0]     i_dist = '0;
    logic                 cfg_we = 1'b0;
    logic [2:0]           cfg_ch = '0;
    logic [1:0]           cfg_op = '0;
    logic                 cfg_commit = 1'b0;
    logic                 o_valid;
    logic [DW-1:0]        o_dist;
    logic [2:0]           o_id;

    sdf_scene_combiner #(
        .NUM_PRIM(NP),
        .DW      (DW),
        .MAX_LAT (MAXL),
        .LAT_VEC (LATS),
        .ID_W    (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid   (i_valid),
        .i_dist    (i_dist),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_op    (cfg_op),
        .cfg_commit(cfg_commit),
        .o_valid   (o_valid),
        .o_dist    (o_dist),
        .o_id      (o_id)
    );

    always #5 clk = ~clk;

    int lat [NP] = '{11, 9, 9, 11};

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    bit [26:0] sched   [NP][NC];
    bit        sched_v [NP][NC];
    bit        exp_v   [NC];
    bit [26:0] exp_d   [NC];
    int        exp_i   [NC];
    bit        rst_at  [NC];

    logic [2*NP-1:0] m_shadow = '0;
    logic [2*NP-1:0] m_active = '0;

    bit          rq_valid, rq_we, rq_commit, rq_rst, pin_en;
    logic [2:0]  rq_ch;
    logic [1:0]  rq_op;
    logic [26:0] rq_d [NP];
    logic [26:0] pin_d;
    int          pin_id;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, expv);
        end
    endtask

    // Signed-magnitude FP27 ordered as a plain integer: magnitude, negated when sign set.
    function automatic longint fval(input logic [26:0] v);
        longint m;
        m = longint'(v[25:0]);
        return v[26] ? -m : m;
    endfunction

    function automatic void fold_ref(input logic [NP*DW-1:0] d, input logic [2*NP-1:0] ops,
                                     output logic [26:0] rd, output int rid);
        logic [26:0] acc, dk, cand;
        bit better;
        acc = (ops[1:0] == 2'b11) ? F_MAX : d[26:0];
        rid = 0;
        for (int k = 1; k < NP; k++) begin
            dk = d[DW*k +: DW];
            cand = dk;
            better = 1'b0;
            case (ops[2*k +: 2])
                2'b00: better = fval(dk) < fval(acc);
                2'b01: better = fval(dk) > fval(acc);
                2'b10: begin
                    cand = {~dk[26], dk[25:0]};
                    better = fval(cand) > fval(acc);
                end
                default: better = 1'b0;
            endcase
            if (better) begin
                acc = cand;
                rid = k;
            end
        end
        rd = acc;
    endfunction

    function automatic logic [26:0] rnd_d();
        case ($urandom_range(0, 6))
            0: return 27'h0;
            1: return F_NZERO;
            2: return F_HALF;
            3: return F_ONE;
            4: return F_NONE;
            5: return F_TWO;
            default: return 27'($urandom);
        endcase
    endfunction

    task automatic tick();
        logic [NP*DW-1:0] dv;
        logic [26:0] rd;
        int rid;
        @(posedge clk);
        #1;
        cyc++;
        if (rq_rst) begin
            reset_n = 1'b0;
            rst_at[cyc] = 1'b1;
            for (int t = cyc; t < NC; t++) exp_v[t] = 1'b0;
            m_shadow = '0;
            m_active = '0;
        end else begin
            reset_n = 1'b1;
            if (rq_valid) begin
                for (int ch = 0; ch < NP; ch++) begin
                    dv[DW*ch +: DW] = rq_d[ch];
                    sched[ch][cyc + lat[ch]] = rq_d[ch];
                    sched_v[ch][cyc + lat[ch]] = 1'b1;
                end
                fold_ref(dv, m_active, rd, rid);
                exp_v[cyc + LATENCY] = 1'b1;
                exp_d[cyc + LATENCY] = rd;
                exp_i[cyc + LATENCY] = rid;
                if (pin_en) begin
                    chk("model_pin_dist", 32'(rd), 32'(pin_d));
                    chk("model_pin_id", rid, pin_id);
                end
            end
            if (rq_commit) m_active = m_shadow;
            if (rq_we && rq_ch < 3'(NP)) m_shadow[2*rq_ch +: 2] = rq_op;
        end
        for (int ch = 0; ch < NP; ch++)
            i_dist[DW*ch +: DW] = sched_v[ch][cyc] ? sched[ch][cyc] : 27'($urandom);
        i_valid    = rq_valid;
        cfg_we     = rq_we;
        cfg_ch     = rq_ch;
        cfg_op     = rq_op;
        cfg_commit = rq_commit;
        if (rq_rst) begin
            #1;
            chk("async_drop_valid", 32'(o_valid), 32'd0);
        end
        rq_valid = 0; rq_we = 0; rq_commit = 0; rq_rst = 0; pin_en = 0;
        rq_ch = '0; rq_op = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic cfg(input int ch, input int op);
        rq_we = 1'b1;
        rq_ch = 3'(ch);
        rq_op = 2'(op);
        tick();
    endtask

    task automatic commit();
        rq_commit = 1'b1;
        tick();
    endtask

    task automatic pinned(input logic [26:0] a, input logic [26:0] b, input logic [26:0] c,
                          input logic [26:0] d, input logic [26:0] pd, input int pid);
        rq_d[0] = a; rq_d[1] = b; rq_d[2] = c; rq_d[3] = d;
        pin_en = 1'b1; pin_d = pd; pin_id = pid;
        rq_valid = 1'b1;
        tick();
    endtask

    task automatic stream(input int n, input int rst_s);
        for (int s = 0; s < n; s++) begin
            for (int ch = 0; ch < NP; ch++) rq_d[ch] = rnd_d();
            rq_valid = 1'b1;
            rq_rst = (s == rst_s);
            tick();
        end
    endtask

    bit [26:0] hold_d = '0;
    int        hold_i = 0;

    always @(negedge clk) begin
        if (rst_at[cyc]) begin
            hold_d = '0;
            hold_i = 0;
        end
        chk("o_valid", 32'(o_valid), 32'(exp_v[cyc]));
        if (exp_v[cyc]) begin
            chk("o_dist", 32'(o_dist), 32'(exp_d[cyc]));
            chk("o_id", 32'(o_id), exp_i[cyc]);
            hold_d = exp_d[cyc];
            hold_i = exp_i[cyc];
        end else begin
            chk("o_dist_hold", 32'(o_dist), 32'(hold_d));
            chk("o_id_hold", 32'(o_id), hold_i);
        end
    end

    initial begin
        rq_valid = 0; rq_we = 0; rq_commit = 0; rq_rst = 0; pin_en = 0;
        rq_ch = '0; rq_op = '0;
        for (int ch = 0; ch < NP; ch++) rq_d[ch] = '0;

        for (int i = 0; i < 3; i++) begin
            rq_rst = 1'b1;
            tick();
        end
        idle(2);

        pinned(F_TWO, F_HALF, F_ONE, F_TWO, F_HALF, 1);

        cfg(1, 2); cfg(2, 3); cfg(3, 3); commit();
        pinned(F_HALF, F_NONE, rnd_d(), rnd_d(), F_ONE, 1);
        pinned(F_HALF, F_ONE, rnd_d(), rnd_d(), F_HALF, 0);

        cfg(1, 0); cfg(2, 0); cfg(3, 0); commit();
        pinned(27'h0, F_NZERO, F_ONE, F_ONE, 27'h0, 0);
        pinned(F_HALF, F_NONE, F_TWO, F_TWO, F_NONE, 1);
        cfg(0, 3); commit();
        pinned(F_MAX, F_MAX, F_MAX, F_MAX, F_MAX, 0);
        cfg(0, 0); commit();

        cfg(7, 1); cfg(4, 2); commit();
        pinned(F_HALF, F_ONE, F_TWO, F_ONE, F_HALF, 0);
        idle(LATENCY + 2);

        for (int s = 0; s < 30; s++) begin
            for (int ch = 0; ch < NP; ch++) rq_d[ch] = rnd_d();
            rq_valid = 1'b1;
            if (s >= 9 && s <= 11) begin
                rq_we = 1'b1;
                rq_ch = 3'(s - 8);
                rq_op = 2'b01;
            end
            rq_commit = (s == 12);
            tick();
        end
        cfg(1, 0); cfg(2, 0); cfg(3, 0); commit();
        idle(LATENCY + 2);

        stream(30, 25);
        idle(3);
        stream(1, -1);
        idle(LATENCY + 2);
        stream(10, 5);
        idle(3);
        stream(1, -1);
        idle(LATENCY + 2);

        for (int i = 0; i < 400; i++) begin
            rq_valid = ($urandom_range(0, 9) < 7);
            for (int ch = 0; ch < NP; ch++) rq_d[ch] = rnd_d();
            if ($urandom_range(0, 3) == 0) begin
                rq_we = 1'b1;
                rq_ch = 3'($urandom_range(0, 7));
                rq_op = 2'($urandom_range(0, 3));
            end
            rq_commit = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle(LATENCY + 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
